piso_reader: RTL

Parallel-in/serial-out reader for the 8-bit register datapath. It accepts a parallel word from a register output (`R`-style bus) under a LOAD/READY handshake. It then shifts the word out one bit per clock with a qualifying valid strobe, and signals completion with a one-cycle DONE pulse. It is the read-out side of the enable-loaded register: the register captures data, and this block unloads it serially.

---
 rtl/piso_reader.sv | 102 ++++++++++
 1 files changed

// File: rtl/piso_reader.sv
// Parallel-in/serial-out reader: loads a word under LOAD/READY and shifts it out
// one bit per clock with SVALID, followed by a one-cycle DONE pulse.
module piso_reader #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA,
    input  logic             LOAD,
    output logic             READY,
    output logic             SOUT,
    output logic             SVALID,
    output logic             DONE
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             sout_q;
    logic             svalid_q;
    logic             done_q;

    // The bit that sits at the output end of a word in the chosen shift order.
    function automatic logic headBit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    always_comb begin
        shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
    end

    // Outputs are registered alongside the state so each one equals its decode
    // of the state it accompanies, with no path from the inputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            sout_q   <= 1'b0;
            svalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (LOAD) begin
                        state_q  <= SHIFT;
                        shreg_q  <= DATA;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        svalid_q <= 1'b1;
                        sout_q   <= headBit(DATA);
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_d;
                    if (cnt_q == LAST_BIT) begin
                        state_q  <= FIN;
                        cnt_q    <= '0;
                        svalid_q <= 1'b0;
                        sout_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + CW'(1);
                        sout_q <= headBit(shreg_d);
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    ready_q  <= 1'b1;
                    sout_q   <= 1'b0;
                    svalid_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign READY  = ready_q;
    assign SOUT   = sout_q;
    assign SVALID = svalid_q;
    assign DONE   = done_q;

endmodule
